ecliptic_fpu_dispatch: RTL and testbench

//  Front end of the ecliptic FPU. Accepts one FP op at a time from the core (valid/ready),

---
 rtl/ecliptic_pkg.sv | 58 +++++
 rtl/ecliptic_fpu_dispatch.sv | 170 +++++++++++++++++
 tb/tb_ecliptic_fpu_dispatch.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/ecliptic_pkg.sv
// Shared types and constants for the ecliptic FPU front end.
// Unit index order matches the u_req/u_ack bit order {CVTW,CVTS,CMP,CLS,BOP}.
package ecliptic_pkg;

  typedef enum logic [2:0] {
    OP_BOP  = 3'd0,
    OP_CLS  = 3'd1,
    OP_CMP  = 3'd2,
    OP_CVTS = 3'd3,
    OP_CVTW = 3'd4
  } op_e;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  typedef struct packed {
    logic qnan;
    logic snan;
    logic pinf;
    logic pnorm;
    logic psub;
    logic pzero;
    logic nzero;
    logic nsub;
    logic nnorm;
    logic ninf;
  } class_result_s;

  localparam int UNIT_BOP  = 0;
  localparam int UNIT_CLS  = 1;
  localparam int UNIT_CMP  = 2;
  localparam int UNIT_CVTS = 3;
  localparam int UNIT_CVTW = 4;
  localparam int NUM_UNITS = 5;

  localparam logic [4:0] FFLAGS_NV = 5'b10000;

  // One-hot unit select; all-zero for an illegal op so no unit is ever requested.
  function automatic logic [NUM_UNITS-1:0] unit_onehot(input logic [2:0] op);
    logic [NUM_UNITS-1:0] oh;
    oh = '0;
    case (op)
      OP_BOP:  oh[UNIT_BOP]  = 1'b1;
      OP_CLS:  oh[UNIT_CLS]  = 1'b1;
      OP_CMP:  oh[UNIT_CMP]  = 1'b1;
      OP_CVTS: oh[UNIT_CVTS] = 1'b1;
      OP_CVTW: oh[UNIT_CVTW] = 1'b1;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/ecliptic_fpu_dispatch.sv
// FPU front end: accepts one op from the core, requests one functional unit,
// waits (bounded) for its ack, and returns result plus RISC-V fflags.
module ecliptic_fpu_dispatch
  import ecliptic_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [2:0]  i_op,
  input  logic [2:0]  i_funct,
  input  logic [31:0] i_src1,
  input  logic [31:0] i_src2,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_res,
  output logic [4:0]  o_fflags,
  output logic [4:0]  o_fflags_acc,
  input  logic        i_fflags_clr,
  output logic [31:0] u_src1,
  output logic [31:0] u_src2,
  output logic [2:0]  u_op,
  output logic [4:0]  u_req,
  input  logic [4:0]  u_ack,
  input  logic [31:0] bop_res,
  input  logic [31:0] cmp_res,
  input  logic [31:0] cvts_res,
  input  logic [31:0] cvtw_res,
  input  logic [9:0]  cls_res,
  input  logic        cmp_invalid,
  input  logic        cvtw_invalid,
  input  logic        cvts_inexact,
  input  logic        cvtw_inexact
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]       state;
  logic [2:0]       op_q;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       sel;
  logic             sel_ack;
  logic             accept;
  logic [31:0]      unit_res;
  fflags_t          unit_flags;
  class_result_s    cls;

  assign o_ready = (state == S_IDLE);
  assign accept  = i_valid && o_ready;
  assign sel     = unit_onehot(op_q);
  assign sel_ack = |(u_ack & sel);

  // Result/flag selection driven purely by the registered op.
  always_comb begin
    unit_res   = '0;
    unit_flags = '0;
    cls        = cls_res;
    case (op_q)
      OP_BOP:  unit_res = bop_res;
      OP_CLS:  unit_res = {22'b0, cls};
      OP_CMP: begin
        unit_res      = cmp_res;
        unit_flags.nv = cmp_invalid;
      end
      OP_CVTS: begin
        unit_res      = cvts_res;
        unit_flags.nx = cvts_inexact;
      end
      OP_CVTW: begin
        unit_res      = cvtw_res;
        unit_flags.nv = cvtw_invalid;
        unit_flags.nx = cvtw_inexact;
      end
      default: begin
        unit_res   = '0;
        unit_flags = '0;
      end
    endcase
  end

  // Operand capture stage: data only, qualified by the accept handshake.
  always_ff @(posedge clk) begin
    if (accept) begin
      u_src1 <= i_src1;
      u_src2 <= i_src2;
      u_op   <= i_funct;
      op_q   <= i_op;
    end
  end

  // Control stage: FSM, unit request, timeout and response registers.
  always_ff @(posedge clk) begin
    if (nrst) begin
      state    <= S_IDLE;
      o_valid  <= 1'b0;
      u_req    <= '0;
      o_res    <= '0;
      o_fflags <= '0;
      cnt      <= '0;
    end else begin
      u_req <= '0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            u_req <= unit_onehot(i_op);
            cnt   <= '0;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // An illegal op spends this slot without a request so latency stays uniform.
          if (sel == '0) begin
            o_res    <= '0;
            o_fflags <= FFLAGS_NV;
            o_valid  <= 1'b1;
            state    <= S_RESP;
          end else if (sel_ack) begin
            o_res    <= unit_res;
            o_fflags <= unit_flags;
            o_valid  <= 1'b1;
            state    <= S_RESP;
          end else begin
            cnt   <= cnt + 1'b1;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (sel_ack) begin
            o_res    <= unit_res;
            o_fflags <= unit_flags;
            o_valid  <= 1'b1;
            state    <= S_RESP;
          end else if (cnt == CNT_W'(TIMEOUT)) begin
            o_res    <= '0;
            o_fflags <= FFLAGS_NV;
            o_valid  <= 1'b1;
            state    <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            state   <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Sticky flags: a same-cycle clear wipes history but keeps the flags being delivered.
  always_ff @(posedge clk) begin
    if (nrst) begin
      o_fflags_acc <= '0;
    end else if (o_valid && i_ready) begin
      o_fflags_acc <= (i_fflags_clr ? 5'b0 : o_fflags_acc) | o_fflags;
    end else if (i_fflags_clr) begin
      o_fflags_acc <= '0;
    end
  end

endmodule

// File: tb/tb_ecliptic_fpu_dispatch.sv
// Directed bench for ecliptic_fpu_dispatch; the bench plays the functional units
// with one-cycle acks carrying hand-computed results.
module tb_ecliptic_fpu_dispatch;

  logic        clk = 1'b0;
  logic        nrst;
  logic        i_valid, o_ready;
  logic [2:0]  i_op, i_funct;
  logic [31:0] i_src1, i_src2;
  logic        o_valid, i_ready;
  logic [31:0] o_res;
  logic [4:0]  o_fflags, o_fflags_acc;
  logic        i_fflags_clr;
  logic [31:0] u_src1, u_src2;
  logic [2:0]  u_op;
  logic [4:0]  u_req, u_ack;
  logic [31:0] bop_res, cmp_res, cvts_res, cvtw_res;
  logic [9:0]  cls_res;
  logic        cmp_invalid, cvtw_invalid, cvts_inexact, cvtw_inexact;

  logic [4:0]  ack_q = '0;
  logic [4:0]  stray;
  logic        auto_ack;
  logic [31:0] v_res;
  logic [9:0]  v_cls;
  logic        v_inv, v_inx;

  int checks = 0;
  int errors = 0;
  int lat;
  logic [4:0] seen;
  logic [2:0] uop1;
  logic [31:0] usrc1;

  always #5 clk = ~clk;

  ecliptic_fpu_dispatch #(.TIMEOUT(16)) dut (
    .clk(clk), .nrst(nrst),
    .i_valid(i_valid), .o_ready(o_ready), .i_op(i_op), .i_funct(i_funct),
    .i_src1(i_src1), .i_src2(i_src2),
    .o_valid(o_valid), .i_ready(i_ready), .o_res(o_res), .o_fflags(o_fflags),
    .o_fflags_acc(o_fflags_acc), .i_fflags_clr(i_fflags_clr),
    .u_src1(u_src1), .u_src2(u_src2), .u_op(u_op), .u_req(u_req), .u_ack(u_ack),
    .bop_res(bop_res), .cmp_res(cmp_res), .cvts_res(cvts_res), .cvtw_res(cvtw_res),
    .cls_res(cls_res), .cmp_invalid(cmp_invalid), .cvtw_invalid(cvtw_invalid),
    .cvts_inexact(cvts_inexact), .cvtw_inexact(cvtw_inexact)
  );

  // Unit models: ack one cycle after req, outputs valid only on the ack cycle.
  always @(posedge clk) ack_q <= auto_ack ? u_req : 5'b0;
  assign u_ack        = ack_q | stray;
  assign bop_res      = ack_q[0] ? v_res : 32'h0;
  assign cls_res      = ack_q[1] ? v_cls : 10'h0;
  assign cmp_res      = ack_q[2] ? v_res : 32'h0;
  assign cvts_res     = ack_q[3] ? v_res : 32'h0;
  assign cvtw_res     = ack_q[4] ? v_res : 32'h0;
  assign cmp_invalid  = ack_q[2] & v_inv;
  assign cvtw_invalid = ack_q[4] & v_inv;
  assign cvts_inexact = ack_q[3] & v_inx;
  assign cvtw_inexact = ack_q[4] & v_inx;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one op and waits (bounded) for o_valid; lat counts cycles after accept.
  task automatic run_op(input logic [2:0] op, input logic [2:0] funct, input logic [31:0] s1);
    i_op = op; i_funct = funct; i_src1 = s1; i_src2 = 32'h0000_0005; i_valid = 1'b1;
    seen = '0;
    step();
    i_valid = 1'b0;
    lat = 1; seen |= u_req; uop1 = u_op; usrc1 = u_src1;
    while (!o_valid && lat < 40) begin
      step();
      lat++;
      seen |= u_req;
    end
  endtask

  task automatic handshake(input logic clr);
    i_ready = 1'b1; i_fflags_clr = clr;
    step();
    i_ready = 1'b0; i_fflags_clr = 1'b0;
  endtask

  initial begin
    nrst = 1'b1; i_valid = 1'b0; i_op = '0; i_funct = '0; i_src1 = '0; i_src2 = '0;
    i_ready = 1'b0; i_fflags_clr = 1'b0; stray = '0; auto_ack = 1'b1;
    v_res = '0; v_cls = '0; v_inv = 1'b0; v_inx = 1'b0;
    step(); step();
    nrst = 1'b0;
    step();
    chk("rst_ready", {31'b0, o_ready}, 32'd1);
    chk("rst_valid", {31'b0, o_valid}, 32'd0);
    chk("rst_ureq", {27'b0, u_req}, 32'd0);
    chk("rst_res", o_res, 32'd0);
    chk("rst_flags", {27'b0, o_fflags}, 32'd0);
    chk("rst_acc", {27'b0, o_fflags_acc}, 32'd0);

    // CVTW signed 3.0f -> 3
    v_res = 32'h0000_0003;
    run_op(3'd4, 3'd0, 32'h4040_0000);
    chk("cvtw_lat", lat, 32'd3);
    chk("cvtw_req", {27'b0, seen}, 32'h10);
    chk("cvtw_src1", usrc1, 32'h4040_0000);
    chk("cvtw_res", o_res, 32'h0000_0003);
    chk("cvtw_flags", {27'b0, o_fflags}, 32'd0);
    handshake(1'b0);
    chk("cvtw_done", {31'b0, o_valid}, 32'd0);

    // CVTS signed -3 -> -3.0f
    v_res = 32'hC040_0000;
    run_op(3'd3, 3'd0, 32'hFFFF_FFFD);
    chk("cvts_s_req", {27'b0, seen}, 32'h08);
    chk("cvts_s_res", o_res, 32'hC040_0000);
    chk("cvts_s_flags", {27'b0, o_fflags}, 32'd0);
    handshake(1'b0);

    // CVTS unsigned 0xFFFFFFFD rounds up to 2^32, inexact
    v_res = 32'h4F80_0000; v_inx = 1'b1;
    run_op(3'd3, 3'd1, 32'hFFFF_FFFD);
    chk("cvts_u_funct", {29'b0, uop1}, 32'd1);
    chk("cvts_u_res", o_res, 32'h4F80_0000);
    chk("cvts_u_flags", {27'b0, o_fflags}, 32'h01);
    handshake(1'b0);
    v_inx = 1'b0;
    chk("acc_nx", {27'b0, o_fflags_acc}, 32'h01);
    i_fflags_clr = 1'b1; step(); i_fflags_clr = 1'b0;
    chk("acc_clr", {27'b0, o_fflags_acc}, 32'd0);

    // BOP passthrough
    v_res = 32'h1234_5678;
    run_op(3'd0, 3'd2, 32'hAAAA_5555);
    chk("bop_req", {27'b0, seen}, 32'h01);
    chk("bop_res", o_res, 32'h1234_5678);
    handshake(1'b0);

    // CLS: result comes from the class mask, not any 32-bit bus
    v_res = 32'hDEAD_BEEF; v_cls = 10'h100;
    run_op(3'd1, 3'd0, 32'h7F80_0001);
    chk("cls_snan", o_res, 32'h0000_0100);
    handshake(1'b0);
    v_cls = 10'h040;
    run_op(3'd1, 3'd0, 32'h3F80_0000);
    chk("cls_pnorm", o_res, 32'h0000_0040);
    chk("cls_flags", {27'b0, o_fflags}, 32'd0);
    handshake(1'b0);

    // Illegal op
    run_op(3'd7, 3'd0, 32'h1111_1111);
    chk("ill_lat", lat, 32'd2);
    chk("ill_req", {27'b0, seen}, 32'd0);
    chk("ill_res", o_res, 32'd0);
    chk("ill_flags", {27'b0, o_fflags}, 32'h10);
    handshake(1'b0);
    chk("ill_acc", {27'b0, o_fflags_acc}, 32'h10);
    step(); step();
    chk("ill_acc_hold", {27'b0, o_fflags_acc}, 32'h10);
    i_fflags_clr = 1'b1; step(); i_fflags_clr = 1'b0;
    chk("ill_acc_clr", {27'b0, o_fflags_acc}, 32'd0);

    // CMP unit never acks; a stray CLS ack must not complete it
    auto_ack = 1'b0; stray = 5'b00010; v_res = 32'h0000_0001;
    run_op(3'd2, 3'd0, 32'h0);
    stray = '0; auto_ack = 1'b1;
    chk("to_lat", lat, 32'd18);
    chk("to_res", o_res, 32'd0);
    chk("to_flags", {27'b0, o_fflags}, 32'h10);
    handshake(1'b0);

    // Core stalls the response for 5 cycles
    v_res = 32'h0000_0001; v_inv = 1'b1;
    run_op(3'd2, 3'd4, 32'h7FC0_0000);
    v_inv = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("hold_valid", {31'b0, o_valid}, 32'd1);
      chk("hold_ready", {31'b0, o_ready}, 32'd0);
      chk("hold_res", o_res, 32'h0000_0001);
      chk("hold_flags", {27'b0, o_fflags}, 32'h10);
      step();
    end
    handshake(1'b0);
    chk("hold_acc", {27'b0, o_fflags_acc}, 32'h10);

    // Reset in the middle of WAIT, then a late ack while idle
    auto_ack = 1'b0;
    i_op = 3'd2; i_funct = 3'd0; i_src1 = 32'h0; i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    step(); step();
    nrst = 1'b1;
    step();
    nrst = 1'b0;
    chk("mid_valid", {31'b0, o_valid}, 32'd0);
    chk("mid_ready", {31'b0, o_ready}, 32'd1);
    chk("mid_acc", {27'b0, o_fflags_acc}, 32'd0);
    chk("mid_ureq", {27'b0, u_req}, 32'd0);
    stray = 5'b00100;
    step();
    stray = '0;
    step();
    chk("late_valid", {31'b0, o_valid}, 32'd0);
    chk("late_ready", {31'b0, o_ready}, 32'd1);
    auto_ack = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
